// File: rtl/mrisc_control_fsm.sv
// Multi-cycle control unit for the KGP mini-RISC datapath: FETCH/DECODE/EXEC/[MEM]/WB
// sequencing, instruction decode, memory timeout and retired-instruction counting.
module mrisc_control_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  opcode_in,
  input  logic [5:0]  func_in,
  input  logic        dmem_ready,
  output logic        ir_load,
  output logic        pc_write,
  output logic [1:0]  reg_write,
  output logic        imm_mux_ctrl,
  output logic        alu_mux_ctrl,
  output logic [3:0]  alu_op,
  output logic        dmem_enable,
  output logic        dmem_write_enable,
  output logic [1:0]  reg_write_mux_ctrl,
  output logic [4:0]  br_op,
  output logic        busy,
  output logic        halted,
  output logic        instr_done,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef struct packed {
    logic       mem;
    logic       store;
    logic [1:0] rw;
    logic       imm;
    logic       amux;
    logic [3:0] aop;
    logic [1:0] wmux;
    logic [4:0] br;
  } dec_t;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  // Halt (opcode 6) is reported as not executable, same path as illegal encodings.
  function automatic logic can_exec(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'd0:                   can_exec = (fn <= 6'd10);
      6'd1, 6'd2, 6'd3, 6'd4: can_exec = 1'b1;
      6'd5:                   can_exec = (fn >= 6'd1) && (fn <= 6'd8);
      default:                can_exec = 1'b0;
    endcase
  endfunction

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d = '0;
    case (op)
      6'd0: begin d.aop = fn[3:0]; d.rw = 2'b01; d.wmux = 2'b10; end
      6'd1: begin d.amux = 1'b1; d.rw = 2'b01; d.wmux = 2'b10; end
      6'd2: begin d.aop = 4'd1; d.amux = 1'b1; d.rw = 2'b01; d.wmux = 2'b10; end
      6'd3: begin d.mem = 1'b1; d.amux = 1'b1; d.rw = 2'b01; d.wmux = 2'b01; end
      6'd4: begin d.mem = 1'b1; d.store = 1'b1; d.amux = 1'b1; end
      6'd5: begin
        d.br  = fn[4:0];
        d.imm = 1'b1;
        if (fn == 6'd6) d.rw = 2'b10;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  state_t      state, state_nx;
  logic [5:0]  op_q, fn_q;
  logic [7:0]  tmo_cnt;
  dec_t        dq;
  logic        ctl_on;

  assign dq = decode(op_q, fn_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= '0;
      fn_q        <= '0;
      tmo_cnt     <= '0;
      instr_count <= '0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) begin
        op_q <= opcode_in;
        fn_q <= func_in;
      end
      if (state == S_EXEC)     tmo_cnt <= '0;
      else if (state == S_MEM) tmo_cnt <= tmo_cnt + 8'd1;
      if (state == S_WB) instr_count <= instr_count + 32'd1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: state_nx = can_exec(opcode_in, func_in) ? S_EXEC : S_HALT;
      S_EXEC:   state_nx = dq.mem ? S_MEM : S_WB;
      // ready in the expiring cycle still completes the access
      S_MEM: begin
        if (dmem_ready)               state_nx = S_WB;
        else if (tmo_cnt >= TMO_LAST) state_nx = S_HALT;
      end
      S_WB:     state_nx = start ? S_FETCH : S_IDLE;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Datapath controls are derived from the latched fields, so they stay stable EXEC..WB.
  always_comb begin
    ctl_on             = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);
    ir_load            = (state == S_FETCH);
    pc_write           = (state == S_WB);
    instr_done         = (state == S_WB);
    reg_write          = (state == S_WB) ? dq.rw : 2'b00;
    dmem_enable        = (state == S_MEM);
    dmem_write_enable  = (state == S_MEM) && dq.store;
    alu_op             = ctl_on ? dq.aop  : 4'd0;
    alu_mux_ctrl       = ctl_on ? dq.amux : 1'b0;
    imm_mux_ctrl       = ctl_on ? dq.imm  : 1'b0;
    reg_write_mux_ctrl = ctl_on ? dq.wmux : 2'b00;
    br_op              = ctl_on ? dq.br   : 5'd0;
    busy               = (state != S_IDLE) && (state != S_HALT);
    halted             = (state == S_HALT);
  end

endmodule

// File: tb/tb_mrisc_control_fsm.sv
// Directed bench for mrisc_control_fsm; WB results checked against a scoreboard queue.
module tb_mrisc_control_fsm;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, dmem_ready = 1'b0;
  logic [5:0]  opcode_in = '0, func_in = '0;
  logic        ir_load, pc_write, imm_mux_ctrl, alu_mux_ctrl, dmem_enable, dmem_write_enable;
  logic        busy, halted, instr_done;
  logic [1:0]  reg_write, reg_write_mux_ctrl;
  logic [3:0]  alu_op;
  logic [4:0]  br_op;
  logic [31:0] instr_count;

  mrisc_control_fsm #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode_in(opcode_in), .func_in(func_in),
    .dmem_ready(dmem_ready), .ir_load(ir_load), .pc_write(pc_write), .reg_write(reg_write),
    .imm_mux_ctrl(imm_mux_ctrl), .alu_mux_ctrl(alu_mux_ctrl), .alu_op(alu_op),
    .dmem_enable(dmem_enable), .dmem_write_enable(dmem_write_enable),
    .reg_write_mux_ctrl(reg_write_mux_ctrl), .br_op(br_op), .busy(busy), .halted(halted),
    .instr_done(instr_done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rw, wmux;
    logic [3:0]  aop;
    logic        amux, imux;
    logic [4:0]  brop;
    bit          chk_alu, chk_mux;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_count = '0;
  int          passed = 0, total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [1:0] rw, input logic [1:0] wmux, input logic [3:0] aop,
                      input logic amux, input logic imux, input logic [4:0] brop,
                      input bit chk_alu, input bit chk_mux);
    exp_t e;
    e.rw = rw; e.wmux = wmux; e.aop = aop; e.amux = amux; e.imux = imux; e.brop = brop;
    e.chk_alu = chk_alu; e.chk_mux = chk_mux; e.cnt = exp_count;
    exp_count++;
    sb.push_back(e);
  endtask

  // WB monitor: every retirement must match the oldest outstanding expectation.
  always @(negedge clk) begin : wb_mon
    exp_t e;
    if (instr_done === 1'b1) begin
      if (sb.size() == 0) check("wb_unexpected", {31'd0, instr_done}, 32'd0);
      else begin
        e = sb.pop_front();
        check("wb_reg_write", reg_write, e.rw);
        check("wb_pc_write", pc_write, 1);
        check("wb_br_op", br_op, e.brop);
        check("wb_imm_mux", imm_mux_ctrl, e.imux);
        check("wb_count", instr_count, e.cnt);
        if (e.chk_mux) check("wb_wmux", reg_write_mux_ctrl, e.wmux);
        if (e.chk_alu) begin
          check("wb_alu_op", alu_op, e.aop);
          check("wb_alu_mux", alu_mux_ctrl, e.amux);
        end
      end
    end
  end

  // Issue one instruction and follow it to WB (or HALT). ready_at = MEM cycle that sees
  // dmem_ready (0 = never); exp_lat counts cycles from FETCH to WB/first HALT cycle.
  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input int ready_at, input bit exp_halt, input int exp_lat,
                     input int exp_mem, input int exp_wr, input bit keep_start);
    int w, lat, mem, wr, strobe;
    opcode_in = op; func_in = fn; start = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (ir_load !== 1'b1 && w < 20);
    check({tag, "_issue"}, w, 1);
    start = keep_start;
    lat = 1; mem = 0; wr = 0; strobe = 0;
    while (!(exp_halt ? halted === 1'b1 : instr_done === 1'b1) && lat < 40) begin
      @(negedge clk);
      lat++;
      if (dmem_enable === 1'b1) mem++;
      if (dmem_write_enable === 1'b1) wr++;
      dmem_ready = (dmem_enable === 1'b1) && (mem == ready_at);
      if (pc_write !== 1'b0 || reg_write !== 2'b00 || instr_done !== 1'b0) strobe++;
      if (lat == 3 && !exp_halt && sb.size() > 0 && sb[$].chk_alu) begin
        check({tag, "_exec_alu_op"}, alu_op, sb[$].aop);
        check({tag, "_exec_alu_mux"}, alu_mux_ctrl, sb[$].amux);
      end
    end
    dmem_ready = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_mem_cycles"}, mem, exp_mem);
    check({tag, "_write_cycles"}, wr, exp_wr);
    if (exp_halt) begin
      check({tag, "_no_strobes"}, strobe, 0);
      check({tag, "_halted_idle"}, {busy, halted}, 2'b01);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    check("reset_halted", halted, 0);
    check("reset_count", instr_count, 0);
    rst = 1'b0;
    exp_count = '0;
    sb.delete();
  endtask

  initial begin
    int w;
    repeat (2) @(negedge clk);
    check("rst_outputs", {ir_load, pc_write, reg_write, dmem_enable, busy, halted, instr_done}, 0);
    check("rst_count", instr_count, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_start", {busy, ir_load}, 0);

    // ALU ops, back-to-back with start held
    push(2'b01, 2'b10, 4'd3, 1'b0, 1'b0, 5'd0, 1, 1);  run("xor",   6'd0, 6'd3,  0, 0, 4, 0, 0, 1);
    push(2'b01, 2'b10, 4'd0, 1'b1, 1'b0, 5'd0, 1, 1);  run("addi",  6'd1, 6'd0,  0, 0, 4, 0, 0, 1);
    push(2'b01, 2'b10, 4'd1, 1'b1, 1'b0, 5'd0, 1, 1);  run("compi", 6'd2, 6'd0,  0, 0, 4, 0, 0, 1);
    push(2'b01, 2'b10, 4'd10, 1'b0, 1'b0, 5'd0, 1, 1); run("diff",  6'd0, 6'd10, 0, 0, 4, 0, 0, 1);
    // memory ops
    push(2'b01, 2'b01, 4'd0, 1'b1, 1'b0, 5'd0, 1, 1);  run("lw",    6'd3, 6'd0,  3, 0, 7, 3, 0, 1);
    push(2'b00, 2'b00, 4'd0, 1'b1, 1'b0, 5'd0, 1, 0);  run("sw",    6'd4, 6'd0,  1, 0, 5, 1, 1, 1);
    // branches
    push(2'b10, 2'b00, 4'd0, 1'b0, 1'b1, 5'd6, 0, 1);  run("bl",    6'd5, 6'd6,  0, 0, 4, 0, 0, 0);
    @(negedge clk);
    check("idle_after_wb", busy, 0);
    check("count_7", instr_count, 7);
    push(2'b00, 2'b00, 4'd0, 1'b0, 1'b1, 5'd1, 0, 0);  run("b",     6'd5, 6'd1,  0, 0, 4, 0, 0, 0);

    // illegal branch func halts; halt is sticky against start
    run("br_func9", 6'd5, 6'd9, 0, 1, 3, 0, 0, 0);
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("halt_sticky", {busy, halted, ir_load}, 3'b010);
    check("halt_count", instr_count, 8);
    do_reset();

    run("halt_op",    6'd6,  6'd0,  0, 1, 3, 0, 0, 0); do_reset();
    run("illegal_7",  6'd7,  6'd0,  0, 1, 3, 0, 0, 0); do_reset();
    run("illegal_63", 6'd63, 6'd0,  0, 1, 3, 0, 0, 0); do_reset();
    run("rfunc_11",   6'd0,  6'd11, 0, 1, 3, 0, 0, 0); do_reset();
    run("br_func0",   6'd5,  6'd0,  0, 1, 3, 0, 0, 0); do_reset();
    run("sw_timeout", 6'd4,  6'd0,  0, 1, 19, 15, 15, 0); do_reset();

    // asynchronous reset in the middle of a memory access
    push(2'b01, 2'b10, 4'd0, 1'b1, 1'b0, 5'd0, 1, 1);  run("addi2", 6'd1, 6'd0, 0, 0, 4, 0, 0, 1);
    opcode_in = 6'd4;
    w = 0;
    while (dmem_enable !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    check("reach_mem", dmem_enable, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", {ir_load, pc_write, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op,
          dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op, busy, halted, instr_done}, 0);
    check("async_rst_count", instr_count, 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {busy, halted}, 0);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mrisc_control_fsm.md
Name: mrisc_control_fsm

Overview:
- Multi-cycle control unit for the KGP mini-RISC datapath.
- Sequences each instruction through FETCH, DECODE, EXEC, optional MEM, and WB.
- Decodes the datapath's opcode_out/func_out and drives every datapath control input: reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op, dmem_enable, dmem_write_enable, reg_write_mux_ctrl and br_op.
- Also drives the IR load and PC write strobes, and halts on a halt instruction or an illegal encoding.

Parameters:
- MEM_TIMEOUT, 15, maximum cycles spent in MEM waiting for dmem_ready before forcing HALT. Range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level; leaves IDLE when sampled high.
- opcode_in  input  6  instruction opcode from the datapath (opcode_out).
- func_in  input  6  function field from the datapath (func_out).
- dmem_ready  input  1  data memory access complete (high in the cycle the access finishes).
- ir_load  output  1  latch the instruction register.
- pc_write  output  1  update the PC with the datapath's pc_new.
- reg_write  output  2  00 none, 01 write rs, 10 write $31 (link).
- imm_mux_ctrl  output  1  0 = sign-extended imm16, 1 = sign-extended 26-bit branch offset.
- alu_mux_ctrl  output  1  0 = rt operand, 1 = immediate operand.
- alu_op  output  4  ALU function select.
- dmem_enable  output  1  data memory enable.
- dmem_write_enable  output  1  data memory write strobe.
- reg_write_mux_ctrl  output  2  10 = ALU result, 01 = memory data, 00 = pc+4.
- br_op  output  5  branch condition select; 0 = no branch.
- busy  output  1  high in every state except IDLE and HALT.
- halted  output  1  high in HALT.
- instr_done  output  1  one-cycle pulse in WB.
- instr_count  output  32  number of retired instructions; wraps at 2^32.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset:
  - Asynchronous; forces state to IDLE.
  - Clears the latched opcode/func registers, the timeout counter and instr_count.
  - Every output is 0 while rst is high and in IDLE.
  - Reset asserted mid-instruction aborts it; no write strobe may be asserted in the reset cycle.
- Transitions:
  - IDLE: goes to FETCH when start = 1.
  - FETCH: ir_load = 1; always goes to DECODE.
  - DECODE:
    - Latches opcode_in/func_in into internal registers; all later decode uses the latched copies.
    - Goes to HALT on halt or illegal encoding, otherwise to EXEC.
  - EXEC: ALU and mux controls valid; goes to MEM for lw/sw, otherwise to WB.
  - MEM:
    - dmem_enable = 1; dmem_write_enable = 1 for sw only.
    - Goes to WB on dmem_ready.
    - After MEM_TIMEOUT cycles without dmem_ready, goes to HALT.
  - WB:
    - reg_write asserted for exactly this cycle when the instruction writes a register.
    - pc_write = 1 and instr_done = 1; instr_count increments.
    - Goes to FETCH if start = 1, else to IDLE.
  - HALT: sticky; exits only via rst.
- ALU/mux controls (alu_op, alu_mux_ctrl, imm_mux_ctrl, reg_write_mux_ctrl, br_op) are held stable from EXEC through WB.
- Decode table:
  - opcode 0, R-type:
    - alu_op = func[3:0] for func 0..10: add, comp, and, xor, shll, shrl, shllv, shrlv, shra, shrav, diff.
    - alu_mux_ctrl = 0; reg_write = 01; reg_write_mux_ctrl = 10.
    - func > 10 is illegal.
  - opcode 1, addi: alu_op = 0, alu_mux_ctrl = 1, imm_mux_ctrl = 0, reg_write = 01, mux = 10.
  - opcode 2, compi: alu_op = 1, otherwise as addi.
  - opcode 3, lw: alu_op = 0, alu_mux_ctrl = 1, reg_write = 01, mux = 01.
  - opcode 4, sw: alu_op = 0, alu_mux_ctrl = 1, reg_write = 00.
  - opcode 5, branch:
    - br_op = func[4:0] for func 1..8: b, br, bltz, bz, bnz, bl, bcy, bncy.
    - imm_mux_ctrl = 1, reg_write = 00.
    - bl (func 6): reg_write = 10, mux = 00.
    - func 0 or func > 8 is illegal.
  - opcode 6, halt: goes to HALT from DECODE with no writes and no pc_write.
  - opcode 7..63: illegal; goes to HALT from DECODE.
- Latency (FETCH to WB inclusive):
  - ALU and branch instructions: 4 cycles.
  - lw/sw: 4 + N cycles, where N ≥ 1 is the number of MEM cycles.
- Simultaneous events:
  - dmem_ready in the same cycle the timeout expires: WB wins.
  - start is ignored outside IDLE and WB.

Test Plan:
- Reset then start = 1, opcode 0, func 3 (xor) -> FETCH/DECODE/EXEC/WB; in WB reg_write = 01, alu_op = 3, mux = 10, pc_write = 1; instr_count = 1.
- opcode 1 (addi) -> in EXEC alu_mux_ctrl = 1, alu_op = 0; in WB reg_write = 01; with start held, back-to-back instructions issue every 4 cycles.
- opcode 3 (lw) with dmem_ready after 3 MEM cycles -> dmem_enable high for 3 cycles, dmem_write_enable = 0, WB mux = 01; total 7 cycles.
- opcode 4 (sw) with dmem_ready never asserted, MEM_TIMEOUT = 15 -> halted = 1 after 15 MEM cycles; no reg_write and no pc_write.
- opcode 5, func 6 (bl) -> br_op = 6, imm_mux_ctrl = 1, WB reg_write = 10, mux = 00. opcode 5, func 9 -> HALT with no strobes.
- rst pulsed during MEM of sw -> all outputs 0 immediately (asynchronous), state IDLE, instr_count = 0.
